// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit type, adjust constants and converter FSM states.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX    = 4'd9;
  localparam bcd_digit_t BCD_ADJ_TH = 4'd8;
  localparam bcd_digit_t BCD_ADJ    = 4'd3;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} b2b_state_t;

endpackage

// File: rtl/bcd_nibble_adj.sv
// Reverse double-dabble nibble correction: a nibble >= 8 after a right shift
// had a "ten" shifted into it from the nibble above, so remove the excess 3.
// Ports:
//   din    in   4  shifted BCD nibble
//   dout_c out  4  corrected nibble (combinational)
module bcd_nibble_adj
  import bcd_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout_c
);

  assign dout_c = (din >= BCD_ADJ_TH) ? bcd_digit_t'(din - BCD_ADJ) : din;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter, one bit per clock (reverse double-dabble).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     input handshake for bcd_in (NDIG packed digits, [3:0]=units)
//   out_valid/out_ready   output handshake for bin_out/err
//   bin_out               binary result (BW bits), 0 when err
//   err                   an input digit was > 9
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter  int unsigned NDIG = 2,
  localparam int unsigned BW   = $clog2(10**NDIG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BW-1:0]     bin_out,
  output logic              err
);

  localparam int unsigned DW = 4 * NDIG;
  localparam int unsigned CW = $clog2(BW);

  b2b_state_t    state;
  logic [DW-1:0] bcd_q;
  logic [BW-1:0] bin_q;
  logic [CW-1:0] cnt;
  logic          err_q;

  logic [DW-1:0] bcd_sh_c;
  logic [DW-1:0] bcd_adj_c;
  logic [BW-1:0] bin_sh_c;
  logic          digit_err_c;

  // Any illegal digit in the incoming word
  always_comb begin
    digit_err_c = 1'b0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (bcd_in[4*i +: 4] > BCD_MAX) digit_err_c = 1'b1;
    end
  end

  // One step: {bcd_q,bin_q} >> 1, then per-nibble correction of the BCD half
  assign bcd_sh_c = {1'b0, bcd_q[DW-1:1]};
  assign bin_sh_c = {bcd_q[0], bin_q[BW-1:1]};

  for (genvar g = 0; g < int'(NDIG); g++) begin : g_adj
    bcd_nibble_adj u_adj (
      .din    (bcd_sh_c[4*g +: 4]),
      .dout_c (bcd_adj_c[4*g +: 4])
    );
  end

  // Control FSM, shift register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      bin_out   <= '0;
      err       <= 1'b0;
      err_q     <= 1'b0;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            bin_q    <= '0;
            if (digit_err_c) begin
              // Error words skip the datapath; DONE raises out_valid next clock
              err_q <= 1'b1;
              state <= DONE;
            end else begin
              bcd_q <= bcd_in;
              cnt   <= '0;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          bcd_q <= bcd_adj_c;
          bin_q <= bin_sh_c;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(BW - 1)) begin
            // Present the result on the final shift edge
            out_valid <= 1'b1;
            bin_out   <= bin_sh_c;
            err       <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            bin_out   <= '0;
            err       <= 1'b0;
            err_q     <= 1'b0;
            state     <= IDLE;
          end else begin
            out_valid <= 1'b1;
            bin_out   <= bin_q;
            err       <= err_q;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
module tb_bcd2bin_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_err;
  logic [7:0] a_bcd;
  logic [6:0] a_bin;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err;
  logic [11:0] b_bcd;
  logic [9:0]  b_bin;

  bcd2bin_seq #(.NDIG(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .bcd_in(a_bcd),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .bin_out(a_bin), .err(a_err)
  );

  bcd2bin_seq #(.NDIG(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .bcd_in(b_bcd),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .bin_out(b_bin), .err(b_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: decimal value of the digits, or error if any digit exceeds 9
  function automatic int ref_bin(input logic [15:0] bcd, input int nd, output int e);
    int v, w, d;
    v = 0; w = 1; e = 0;
    for (int i = 0; i < nd; i++) begin
      d = int'(bcd[4*i +: 4]);
      if (d > 9) e = 1;
      v = v + d * w;
      w = w * 10;
    end
    return (e != 0) ? 0 : v;
  endfunction

  // Called at posedge+1 with the DUT idle; returns latency and result
  task automatic send_a(input logic [7:0] bcd, output int lat, output int b, output int e);
    chk("a_in_ready_before_accept", int'(a_in_ready), 1);
    a_bcd = bcd; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_bcd = 8'($urandom);
    lat = 0;
    while (!a_out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    b = int'(a_bin); e = int'(a_err);
    if (a_out_valid && !a_err) chk("a_bcd_q_zero_at_done", int'(dut_a.bcd_q), 0);
    if (a_out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_b(input logic [11:0] bcd, output int lat, output int b, output int e);
    chk("b_in_ready_before_accept", int'(b_in_ready), 1);
    b_bcd = bcd; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    b = int'(b_bin); e = int'(b_err);
    if (b_out_valid && !b_err) chk("b_bcd_q_zero_at_done", int'(dut_b.bcd_q), 0);
    @(posedge clk); #1;
  endtask

  task automatic model_a(input logic [7:0] bcd, input string nm);
    int lat, b, e, xb, xe;
    xb = ref_bin({8'h00, bcd}, 2, xe);
    send_a(bcd, lat, b, e);
    chk({nm, "_lat"}, lat, (xe != 0) ? 1 : 7);
    chk({nm, "_bin"}, b, xb);
    chk({nm, "_err"}, e, xe);
  endtask

  task automatic model_b(input logic [11:0] bcd, input string nm);
    int lat, b, e, xb, xe;
    xb = ref_bin({4'h0, bcd}, 3, xe);
    send_b(bcd, lat, b, e);
    chk({nm, "_lat"}, lat, (xe != 0) ? 1 : 10);
    chk({nm, "_bin"}, b, xb);
    chk({nm, "_err"}, e, xe);
  endtask

  typedef struct {
    logic [7:0] bcd;
    int         bin;
    int         e;
    int         lat;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, b, e;
    logic [7:0]  ra;
    logic [11:0] rb;

    tbl[0] = '{8'h99, 99, 0, 7};
    tbl[1] = '{8'h00,  0, 0, 7};
    tbl[2] = '{8'h1A,  0, 1, 1};
    tbl[3] = '{8'h10, 10, 0, 7};
    tbl[4] = '{8'h42, 42, 0, 7};
    tbl[5] = '{8'hF0,  0, 1, 1};
    tbl[6] = '{8'h09,  9, 0, 7};
    tbl[7] = '{8'h90, 90, 0, 7};
    tbl[8] = '{8'h9F,  0, 1, 1};
    tbl[9] = '{8'h55, 55, 0, 7};

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_bcd = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_bcd = '0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_in_ready", int'(a_in_ready), 1);
    chk("rst_a_out_valid", int'(a_out_valid), 0);
    chk("rst_a_bin", int'(a_bin), 0);
    chk("rst_a_err", int'(a_err), 0);
    chk("rst_b_in_ready", int'(b_in_ready), 1);
    chk("rst_b_out_valid", int'(b_out_valid), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      send_a(tbl[i].bcd, lat, b, e);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_bin", i), b, tbl[i].bin);
      chk($sformatf("tbl%0d_err", i), e, tbl[i].e);
    end

    // Every legal two-digit code
    for (int t = 0; t < 10; t++)
      for (int u = 0; u < 10; u++)
        model_a(8'(t * 16 + u), "sweep");

    // Random words, legal and illegal
    for (int i = 0; i < 150; i++) begin
      ra = 8'($urandom);
      model_a(ra, "rand_a");
    end

    // Backpressure: result held, input ignored while busy
    a_out_ready = 1'b0;
    a_bcd = 8'h42; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    lat = 0;
    while (!a_out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("bp_lat", lat, 7);
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1'b1; a_bcd = 8'h77;
      @(posedge clk); #1;
      chk("bp_out_valid_held", int'(a_out_valid), 1);
      chk("bp_bin_held", int'(a_bin), 42);
      chk("bp_in_ready_low", int'(a_in_ready), 0);
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", int'(a_out_valid), 0);
    chk("bp_release_in_ready", int'(a_in_ready), 1);
    model_a(8'h05, "bp_next");

    // Reset mid-conversion discards the word
    a_bcd = 8'h57; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_cnt", int'(dut_a.cnt), 3);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", int'(a_in_ready), 1);
    chk("midrst_out_valid", int'(a_out_valid), 0);
    chk("midrst_bin", int'(a_bin), 0);
    chk("midrst_err", int'(a_err), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_no_result", int'(a_out_valid), 0);
    model_a(8'h05, "midrst_next");

    // Three-digit instance
    model_b(12'h999, "b999");
    model_b(12'h000, "b000");
    model_b(12'h9A9, "b9a9");
    model_b(12'h512, "b512");
    for (int i = 0; i < 20; i++) begin
      if (i % 4 == 3) rb = 12'($urandom);
      else rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      model_b(rb, "rand_b");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
